score_keeper: RTL

//   Game-side scoring stage, directly upstream of Seven_Seg_Display.
//   - Accepts hit/miss events from game logic and accumulates a 4-digit BCD score.
//   - Tracks remaining lives and runs the IDLE/PLAY/OVER game state.
//   - Drives the display's get_score, score_signal (toggle-per-update) and game_end.

---
 rtl/score_keeper.sv | 109 ++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Game scoring stage: accumulates a 4-digit BCD score, tracks lives and runs
// the IDLE/PLAY/OVER game state feeding the seven-segment display.
module score_keeper #(
    parameter int unsigned LIVES_INIT = 3,
    parameter logic [15:0] WIN_SCORE  = 16'h0999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hit_valid,
    input  logic [3:0]  hit_points,
    input  logic        miss,
    output logic [15:0] bcd_score,
    output logic [3:0]  get_score,
    output logic        score_signal,
    output logic [1:0]  lives,
    output logic        game_end,
    output logic        playing
);

    localparam int unsigned DIGITS    = 4;
    localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);
    localparam logic [15:0] SCORE_MAX = 16'h9999;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } state_t;

    state_t      state;
    logic [3:0]  points_c;
    logic [15:0] sum_c;
    logic        carry_c;
    logic [4:0]  digit_c;
    logic        end_c;

    assign points_c = (hit_points > 4'd9) ? 4'd9 : hit_points;

    // Decimal ripple add of the clamped points; saturate instead of wrapping.
    always_comb begin
        sum_c   = '0;
        carry_c = 1'b0;
        digit_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_c = 5'(bcd_score[i*4 +: 4]) + 5'(carry_c)
                    + ((i == 0) ? 5'(points_c) : 5'd0);
            if (digit_c > 5'd9) begin
                sum_c[i*4 +: 4] = 4'(digit_c - 5'd10);
                carry_c         = 1'b1;
            end else begin
                sum_c[i*4 +: 4] = digit_c[3:0];
                carry_c         = 1'b0;
            end
        end
        if (carry_c) begin
            sum_c = SCORE_MAX;
        end
    end

    // Lives can only reach zero via a miss while a single life remains.
    assign end_c = (hit_valid && (sum_c >= WIN_SCORE)) || (miss && (lives <= 2'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bcd_score    <= '0;
            get_score    <= '0;
            score_signal <= 1'b0;
            lives        <= LIVES_RST;
            game_end     <= 1'b0;
            playing      <= 1'b0;
        end else begin
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state     <= PLAY;
                        bcd_score <= '0;
                        get_score <= '0;
                        lives     <= LIVES_RST;
                        game_end  <= 1'b0;
                        playing   <= 1'b1;
                    end
                end
                PLAY: begin
                    if (hit_valid) begin
                        bcd_score    <= sum_c;
                        get_score    <= points_c;
                        score_signal <= ~score_signal;
                    end
                    if (miss && (lives != 2'd0)) begin
                        lives <= lives - 2'd1;
                    end
                    if (end_c) begin
                        state    <= OVER;
                        playing  <= 1'b0;
                        game_end <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    playing  <= 1'b0;
                    game_end <= 1'b0;
                end
            endcase
        end
    end

endmodule
